axi_xbar_wrr_arb: RTL and testbench
===================================

# axi_xbar_wrr_arb

Weighted round-robin arbiter for one master-side AW or AR channel of the AXI crossbar. It replaces the fixed rotate-on-accept arbiter. Each normal requester receives a programmable number of consecutive accepted grants per turn. The top-index requester (the wide-address slave port) keeps strict priority, bounded by a starvation guard. Grant outputs are combinational from `reqs` and registered state. State advances only on an accepted handshake.

## Interface
- `NUM_REQ`, 5: number of requesters. Index `NUM_REQ-1` is the priority requester. Indices `0..NUM_REQ-2` are normal requesters.
- `W_BITS`, 4: weight width.
- `WEIGHT_RST`, 1: reset weight for every normal requester.
- `STARVE_MAX`, 8: maximum consecutive priority grants while any normal request is pending.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `reqs`, in, `NUM_REQ`: request vector (per-slave valid for this master).
- `ready`, in, 1: downstream accepts the granted beat (`mi_reg` ready && !meta-FIFO full).
- `grant_valid`, out, 1: `|reqs`.
- `grant_b`, out, `NUM_REQ`: one-hot grant, or all zero when `grant_valid` = 0.
- `grant_i`, out, `$clog2(NUM_REQ)`: granted index, or 0 when `grant_valid` = 0.
- `cfg_we`, in, 1: weight write strobe.
- `cfg_idx`, in, `$clog2(NUM_REQ)`: weight index to write.
- `cfg_weight`, in, `W_BITS`: weight value to write.
- `stat_idx`, in, `$clog2(NUM_REQ)`: statistics select.
- `stat_cnt`, out, 32: accepted-grant count for `stat_idx`.

## Operation
- Registered state:
  - `ptr`: favoured normal index, range `0..NUM_REQ-2`.
  - `used`: grants consumed by `ptr`, `W_BITS` wide.
  - `starve`: consecutive priority grants, saturates at `STARVE_MAX`.
  - `weight[0..NUM_REQ-2]`.
- Reset: `ptr`=0, `used`=0, `starve`=0, all weights = `WEIGHT_RST`, stat counters = 0.
- Outputs under reset are combinational from the reset state. With `reqs`=0: `grant_valid`=0, `grant_b`=0, `grant_i`=0.
- Effective weight: a stored weight of 0 is treated as 1.
- Selection, evaluated every cycle:
  - P = `reqs[NUM_REQ-1]`; N = any of `reqs[NUM_REQ-2:0]`.
  - P && (!N || `starve` < `STARVE_MAX`): grant `NUM_REQ-1`.
  - Otherwise, if N: grant the first set bit scanning cyclically from `ptr` upward through `0..NUM_REQ-2`.
- Update on accept (`ready && grant_valid`) to index g:
  - g = priority: `starve` <= N ? min(`starve`+1, `STARVE_MAX`) : 0. `ptr` and `used` are unchanged.
  - g normal: `starve` <= 0. Compute u = (g == `ptr`) ? `used`+1 : 1.
  - If u >= effective `weight[g]`: `ptr` <= (g+1) mod (`NUM_REQ`-1) and `used` <= 0.
  - Otherwise: `ptr` <= g and `used` <= u.
- No accept: state holds. Grant may change if `reqs` changes; the upstream holds valid, so a pending grant is stable.
- Config writes:
  - `cfg_we` with `cfg_idx` <= `NUM_REQ-2` writes `weight[cfg_idx]`.
  - Writes with `cfg_idx` = `NUM_REQ-1` or out of range are ignored.
  - A write and an accept in the same cycle: the accept uses the old weight.
  - Lowering the weight of `ptr` below `used` causes rotation on its next accept, via the >= compare.
- Reset asserted mid-burst: all state clears immediately.

## Timing
- Grant latency is 0 cycles (combinational from `reqs`).
- State updates on the rising `clk` edge after an accept. A new weight is visible to selection in the cycle after the write.
- Back-to-back accepts every cycle are supported. The W-beat ordering owned by the crossbar meta FIFOs is unaffected, because arbitration is per AW/AR beat.
- `stat_cnt` is a combinational read of the registered counter.

## Configuration
- `AXI_XBAR_ARB_STATS_EN` defined: one 32-bit counter per requester (priority requester included). Each counter increments on every accepted grant to its index, wraps at 2^32, and is cleared by reset.
- Not defined: no counters; `stat_cnt` is tied to 0 and `stat_idx` is ignored.

## Structure
- `axi_xbar_pkg` holds `W_BITS` default, `STARVE_MAX` default, and the typedef `arb_weight_t`. The crossbar and the future CSR block import it.
- Sub-module `axi_xbar_rr_pick`: a combinational cyclic priority encoder taking (`reqs[NUM_REQ-2:0]`, `ptr`) and producing a one-hot and an index. It is instantiated once.

## Test plan
- Weights {1,1,1,1}, `reqs`=0b01111, `ready`=1 for 8 cycles -> `grant_i` sequence 0,1,2,3,0,1,2,3.
- Weights {3,1,2,1}, `reqs`=0b01111, `ready`=1 -> 0,0,0,1,2,2,3,0,0,0.
- `reqs`=0b10001, `STARVE_MAX`=8, `ready`=1 -> 8 grants to index 4, then 1 grant to index 0, then 4 again; `starve` returns to 0 after the normal grant.
- `reqs`=0b00101 with `ready`=0 for 5 cycles -> `grant_i`=0 held, state unchanged. Then `ready`=1 -> accept 0; with weight 1 the next grant is 2.
- Weight[0]=4, after 2 accepts to 0, write `cfg_weight`=1 to idx 0 -> next accept to 0 rotates `ptr` to 1. A write to idx 4 has no effect.
- `AXI_XBAR_ARB_STATS_EN`: 10 accepts to index 2, then `stat_idx`=2 -> `stat_cnt`=10. Assert `rst_n`=0 mid-sequence -> `stat_cnt`=0, `ptr`=0, and `grant_valid`=0 once `reqs`=0.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// axi_xbar_pkg: shared arbiter defaults and weight type for the crossbar and CSR block
package axi_xbar_pkg;
    localparam int W_BITS_DEF = 4;
    localparam int STARVE_MAX_DEF = 8;
    typedef logic [W_BITS_DEF-1:0] arb_weight_t;
endpackage

// File: rtl/axi_xbar_wrr_arb_if.sv
// axi_xbar_wrr_arb_if: request/grant handshake between AW/AR sources and the arbiter
interface axi_xbar_wrr_arb_if #(
    parameter int NUM_REQ = 5
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] reqs;
    logic               ready;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant_b;
    logic [IW-1:0]      grant_i;
    modport master (output reqs, ready, input grant_valid, grant_b, grant_i);
    modport slave  (input reqs, ready, output grant_valid, grant_b, grant_i);
endinterface

// File: rtl/axi_xbar_rr_pick.sv
// axi_xbar_rr_pick: cyclic priority encoder, first set request at or after ptr
module axi_xbar_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_b,
    output logic [PW-1:0] grant_i
);
    logic [PW-1:0] j;
    always_comb begin
        j = '0;
        grant_i = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % N);
            grant_i = req[j] ? j : grant_i;
        end
        grant_b = |req ? N'(1) << grant_i : '0;
    end
endmodule

// File: rtl/axi_xbar_wrr_arb.sv
// axi_xbar_wrr_arb: weighted round-robin with starvation-bounded priority top index; AXI_XBAR_ARB_STATS_EN adds grant counters
module axi_xbar_wrr_arb
    import axi_xbar_pkg::*;
#(
    parameter int NUM_REQ    = 5,
    parameter int W_BITS     = W_BITS_DEF,
    parameter int WEIGHT_RST = 1,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi_xbar_wrr_arb_if.slave          bus,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0] cfg_idx,
    input  logic [W_BITS-1:0]          cfg_weight,
    input  logic [$clog2(NUM_REQ)-1:0] stat_idx,
    output logic [31:0]                stat_cnt
);
    localparam int NN = NUM_REQ - 1;
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = NN > 1 ? $clog2(NN) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [PW-1:0]     ptr, pick_i, ptr_inc;
    logic [NN-1:0]     pick_b;
    logic [W_BITS-1:0] used, weff;
    logic [W_BITS-1:0] weight [NN];
    logic [W_BITS:0]   u;
    logic [SW-1:0]     starve;
    logic              p, n, take_p, acc, rotate;

    axi_xbar_rr_pick #(.N(NN), .PW(PW)) u_pick (
        .req     (bus.reqs[NN-1:0]),
        .ptr     (ptr),
        .grant_b (pick_b),
        .grant_i (pick_i)
    );

    always_comb begin
        p = bus.reqs[NN];
        n = |bus.reqs[NN-1:0];
        take_p = p && (!n || starve < SW'(STARVE_MAX));
        acc = bus.ready && bus.grant_valid;
        weff = weight[pick_i] == '0 ? W_BITS'(1) : weight[pick_i];
        u = pick_i == ptr ? {1'b0, used} + (W_BITS+1)'(1) : (W_BITS+1)'(1);
        rotate = u >= {1'b0, weff};
        ptr_inc = pick_i == PW'(NN - 1) ? '0 : pick_i + PW'(1);
    end

    assign bus.grant_valid = |bus.reqs;
    assign bus.grant_b = take_p ? {1'b1, {NN{1'b0}}} : {1'b0, pick_b};
    assign bus.grant_i = take_p ? IW'(NN) : n ? IW'(pick_i) : '0;

    // priority grants never move the normal rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            used <= '0;
            starve <= '0;
        end else if (acc && take_p) begin
            starve <= !n ? '0 : starve == SW'(STARVE_MAX) ? starve : starve + SW'(1);
        end else if (acc) begin
            starve <= '0;
            ptr <= rotate ? ptr_inc : pick_i;
            used <= rotate ? '0 : u[W_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++) weight[i] <= W_BITS'(WEIGHT_RST);
        end else if (cfg_we && int'(cfg_idx) < NN) begin
            weight[cfg_idx[PW-1:0]] <= cfg_weight;
        end
    end

`ifdef AXI_XBAR_ARB_STATS_EN
    logic [31:0] cnt [NUM_REQ];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (acc) begin
            cnt[bus.grant_i] <= cnt[bus.grant_i] + 32'd1;
        end
    end
    assign stat_cnt = int'(stat_idx) < NUM_REQ ? cnt[stat_idx] : '0;
`else
    logic stat_unused;
    assign stat_unused = ^stat_idx;
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_axi_xbar_wrr_arb.sv
// tb_axi_xbar_wrr_arb: randomized and directed check of the WRR arbiter against a behavioural model
module tb_axi_xbar_wrr_arb;
    import axi_xbar_pkg::*;
    localparam int NR = 5;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cfg_we = 0;
    logic [2:0]  cfg_idx = 0;
    logic [2:0]  stat_idx = 0;
    arb_weight_t cfg_weight = 0;
    logic [31:0] stat_cnt;

    axi_xbar_wrr_arb_if #(.NUM_REQ(NR)) bus ();

    axi_xbar_wrr_arb #(.NUM_REQ(NR), .W_BITS(4), .WEIGHT_RST(1), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .stat_idx   (stat_idx),
        .stat_cnt   (stat_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_ptr, m_used, m_starve;
    int          m_w [4];
    logic [31:0] m_cnt [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_used = 0;
        m_starve = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endtask

    function automatic int exp_g(input logic [4:0] r);
        if (r[4] && (r[3:0] == 0 || m_starve < 8)) return 4;
        for (int k = 0; k < 4; k++)
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        int g, u, ew;
        longint es;
        if (!rst_n) model_reset();
        g = exp_g(bus.reqs);
        chk("grant_valid", bus.grant_valid, bus.reqs != 0);
        chk("grant_i", bus.grant_i, g < 0 ? 0 : g);
        chk("grant_b", bus.grant_b, g < 0 ? 0 : (1 << g));
`ifdef AXI_XBAR_ARB_STATS_EN
        es = stat_idx < 5 ? m_cnt[stat_idx] : 0;
`else
        es = 0;
`endif
        chk("stat_cnt", stat_cnt, es);
        if (rst_n) begin
            if (bus.ready && g >= 0) begin
                m_cnt[g] = m_cnt[g] + 1;
                if (g == 4) begin
                    m_starve = bus.reqs[3:0] != 0 ? (m_starve < 8 ? m_starve + 1 : 8) : 0;
                end else begin
                    m_starve = 0;
                    u = g == m_ptr ? m_used + 1 : 1;
                    ew = m_w[g] == 0 ? 1 : m_w[g];
                    if (u >= ew) begin
                        m_ptr = (g + 1) % 4;
                        m_used = 0;
                    end else begin
                        m_ptr = g;
                        m_used = u;
                    end
                end
            end
            if (cfg_we && cfg_idx < 4) m_w[cfg_idx] = cfg_weight;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int w);
        cfg_we = 1;
        cfg_idx = 3'(idx);
        cfg_weight = 4'(w);
        tick();
        cfg_we = 0;
    endtask

    task automatic run_seq(input string nm, input int seq[], input logic [4:0] r);
        bus.reqs = r;
        bus.ready = 1;
        foreach (seq[k]) begin
            #1 chk(nm, bus.grant_i, seq[k]);
            tick();
        end
        bus.ready = 0;
        bus.reqs = 0;
    endtask

    initial begin
        int s1[] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int s2[] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        int s3[] = '{4, 4, 4, 4, 4, 4, 4, 4, 0, 4, 4, 4, 4, 4, 4, 4, 4, 0};
        bus.reqs = 0;
        bus.ready = 0;
        tick();
        tick();
        chk("rst_grant_valid", bus.grant_valid, 0);
        chk("rst_grant_i", bus.grant_i, 0);
        chk("rst_grant_b", bus.grant_b, 0);
        rst_n = 1;
        tick();
        run_seq("seq_equal_w", s1, 5'b01111);
        wr(0, 3);
        wr(1, 1);
        wr(2, 2);
        wr(3, 1);
        run_seq("seq_weighted", s2, 5'b01111);
        run_seq("seq_starve", s3, 5'b10001);
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.reqs = 5'b00101;
        bus.ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("hold_no_ready", bus.grant_i, 0);
            tick();
        end
        bus.ready = 1;
        #1 chk("hold_accept", bus.grant_i, 0);
        tick();
        chk("hold_next", bus.grant_i, 2);
        bus.ready = 0;
        bus.reqs = 0;
        wr(0, 4);
        bus.reqs = 5'b00001;
        bus.ready = 1;
        tick();
        tick();
        bus.ready = 0;
        bus.reqs = 0;
        wr(0, 1);
        wr(4, 15);
        wr(5, 15);
        bus.reqs = 5'b00011;
        bus.ready = 1;
        #1 chk("lower_w_first", bus.grant_i, 0);
        tick();
        chk("lower_w_rotate", bus.grant_i, 1);
        tick();
        chk("lower_w_wrap", bus.grant_i, 0);
        bus.ready = 0;
        bus.reqs = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        stat_idx = 2;
        bus.reqs = 5'b00100;
        bus.ready = 1;
        repeat (10) tick();
        bus.ready = 0;
        #1;
`ifdef AXI_XBAR_ARB_STATS_EN
        chk("stat_ten", stat_cnt, 10);
`else
        chk("stat_off", stat_cnt, 0);
`endif
        bus.ready = 1;
        repeat (3) tick();
        rst_n = 0;
        #1 chk("midrst_stat", stat_cnt, 0);
        chk("midrst_grant_i", bus.grant_i, 2);
        bus.reqs = 0;
        #1 chk("midrst_valid", bus.grant_valid, 0);
        chk("midrst_idx", bus.grant_i, 0);
        tick();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.reqs = 5'($urandom_range(0, 31));
            bus.ready = $urandom_range(0, 3) != 0;
            cfg_we = $urandom_range(0, 7) == 0;
            cfg_idx = 3'($urandom_range(0, 7));
            cfg_weight = 4'($urandom_range(0, 15));
            stat_idx = 3'($urandom_range(0, 7));
            rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        cfg_we = 0;
        bus.ready = 0;
        bus.reqs = 0;
        rst_n = 1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
